// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: occupancy state encoding,
// default field widths and the bubble counter width.
package pipe_stage_reg_pkg;

    localparam int DEF_DATA_W = 96;
    localparam int DEF_CTRL_W = 6;
    localparam int BUBBLE_W   = 16;

    // Encoding doubles as the entry count reported on the occupancy port.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry: valid + ctrl + payload. Flush clears valid and ctrl but
// keeps the payload; flush wins over load, load wins over drop.
module pipe_entry #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 96
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic              flush_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flushable pipeline stage: two-entry skid buffer (SKID=1, registered in_ready)
// or a single register (SKID=0, combinational in_ready).
//   state    | meaning
//   ST_EMPTY | no entry held
//   ST_ONE   | main entry valid
//   ST_TWO   | main and skid entries valid, upstream stalled
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                interrupt,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          occupancy,
    output logic                irq_taken,
    output logic [BUBBLE_W-1:0] bubble_cnt
);

    occ_state_e          state_q, state_d;
    logic                in_ready_q;
    logic                irq_q;
    logic [BUBBLE_W-1:0] bubble_q, bubble_d;

    logic                squash, accept, deliver;
    logic                main_ld, main_drop, main_src_skid;
    logic                skid_ld, skid_drop;
    logic                main_valid, skid_valid;
    logic [CTRL_W-1:0]   main_ctrl, skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0]   main_data, skid_data, main_data_in;

    assign squash  = flush | interrupt;
    assign accept  = in_valid & in_ready;
    assign deliver = main_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        if (squash) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !deliver && SKID != 0) state_d = ST_TWO;
                    else if (!accept && deliver)         state_d = ST_EMPTY;
                end
                ST_TWO:   if (deliver) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_ld       = 1'b0;
        main_drop     = 1'b0;
        main_src_skid = 1'b0;
        skid_ld       = 1'b0;
        skid_drop     = 1'b0;
        case (state_q)
            ST_EMPTY: main_ld = accept;
            ST_ONE: begin
                main_ld   = accept && deliver;
                main_drop = deliver && !accept;
                skid_ld   = accept && !deliver;
            end
            ST_TWO: begin
                main_ld       = deliver;
                main_src_skid = 1'b1;
                skid_drop     = deliver;
            end
            default: ;
        endcase
    end

    assign main_ctrl_in = main_src_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_src_skid ? skid_data : in_data;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (main_ld),
        .drop_i  (main_drop),
        .flush_i (squash),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk_i   (clk),
            .rst_i   (reset),
            .load_i  (skid_ld),
            .drop_i  (skid_drop),
            .flush_i (squash),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .valid_o (skid_valid),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
        );
    end else begin : g_noskid
        assign skid_valid = 1'b0;
        assign skid_ctrl  = '0;
        assign skid_data  = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q    <= 1'b0;
            bubble_q <= '0;
        end else begin
            irq_q    <= interrupt;
            bubble_q <= bubble_d;
        end
    end

    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !main_valid && bubble_q != '1) bubble_d = bubble_q + 1'b1;
    end

    // The single-register variant can reload in the same cycle it drains.
    assign in_ready   = (SKID != 0) ? in_ready_q : (!main_valid || out_ready);
    assign out_valid  = main_valid;
    assign out_ctrl   = main_valid ? main_ctrl : '0;
    assign out_data   = main_data;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign irq_taken  = irq_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage with identical stimulus and compares both
// against a queue-based reference model every cycle.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [5:0]  c;
        logic [95:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy_o [2];
    logic        vld_o [2];
    logic [5:0]  ctl_o [2];
    logic [95:0] dat_o [2];
    logic [1:0]  occ_o [2];
    logic        irq_o [2];
    logic [15:0] bub_o [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(6), .SKID(1)) dut0 (
        .clk(clk), .reset(reset), .interrupt(interrupt), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_o[0]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(vld_o[0]), .out_ready(out_ready), .out_ctrl(ctl_o[0]), .out_data(dat_o[0]),
        .occupancy(occ_o[0]), .irq_taken(irq_o[0]), .bubble_cnt(bub_o[0])
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(6), .SKID(0)) dut1 (
        .clk(clk), .reset(reset), .interrupt(interrupt), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_o[1]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(vld_o[1]), .out_ready(out_ready), .out_ctrl(ctl_o[1]), .out_data(dat_o[1]),
        .occupancy(occ_o[1]), .irq_taken(irq_o[1]), .bubble_cnt(bub_o[1])
    );

    int          errors = 0;
    int          checks = 0;
    beat_t       q0[$];
    beat_t       q1[$];
    logic [95:0] hdata [2];
    int          bub [2];
    logic        irq_exp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qhd(input int d);
        beat_t b;
        b = '0;
        if (d == 0) begin
            if (q0.size() > 0) b = q0[0];
        end else begin
            if (q1.size() > 0) b = q1[0];
        end
        return b;
    endfunction

    task automatic qpush(input int d, input beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic qpop(input int d);
        beat_t b;
        if (d == 0) b = q0.pop_front();
        else        b = q1.pop_front();
    endtask

    task automatic qclear(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            qclear(d);
            hdata[d] = '0;
            bub[d]   = 0;
        end
        irq_exp = 1'b0;
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, advance the model.
    task automatic step(input logic r, input logic iv, input logic [5:0] ic, input logic [95:0] id,
                        input logic ordy, input logic fl, input logic ir);
        int    sz;
        beat_t hb;
        logic  mrdy;
        logic  acc [2];
        logic  del [2];
        @(negedge clk);
        reset     = r;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        interrupt = ir;
        if (r) model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            sz   = qsz(d);
            hb   = qhd(d);
            mrdy = (d == 0) ? (sz < 2) : (sz == 0 || ordy);
            chk($sformatf("occupancy%0d", d), 128'(occ_o[d]), 128'(sz));
            chk($sformatf("out_valid%0d", d), 128'(vld_o[d]), 128'(sz > 0));
            chk($sformatf("out_ctrl%0d", d), 128'(ctl_o[d]), (sz > 0) ? 128'(hb.c) : 128'(0));
            chk($sformatf("out_data%0d", d), 128'(dat_o[d]), (sz > 0) ? 128'(hb.d) : 128'(hdata[d]));
            chk($sformatf("in_ready%0d", d), 128'(rdy_o[d]), 128'(mrdy));
            chk($sformatf("irq_taken%0d", d), 128'(irq_o[d]), 128'(irq_exp));
            chk($sformatf("bubble_cnt%0d", d), 128'(bub_o[d]), 128'(bub[d]));
            acc[d] = !r && !(fl || ir) && iv && mrdy;
            del[d] = !r && !(fl || ir) && (sz > 0) && ordy;
            if (!r && ordy && sz == 0 && bub[d] < 65535) bub[d]++;
        end
        @(posedge clk);
        irq_exp = ir && !r;
        for (int d = 0; d < 2; d++) begin
            if (!r) begin
                if (fl || ir) begin
                    qclear(d);
                end else begin
                    if (del[d]) qpop(d);
                    if (acc[d]) qpush(d, {ic, id});
                end
                if (qsz(d) > 0) begin
                    hb = qhd(d);
                    hdata[d] = hb.d;
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, 96'h0, ordy, 1'b0, 1'b0);
    endtask

    function automatic logic [95:0] pay(input int k);
        return {32'hC0DE_0000 + 32'(k), 64'h5A5A_0000_0000_0000 | 64'(k)};
    endfunction

    initial begin
        model_reset();
        step(1'b1, 1'b0, 6'h00, 96'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'h15, pay(99), 1'b1, 1'b0, 1'b0);

        // Streaming 1..8 with downstream always ready.
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 6'(k), 96'(k), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Backpressure: A, B, C while stalled, then release.
        step(1'b0, 1'b1, 6'h0A, pay(10), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h0B, pay(11), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h0C, pay(12), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h0C, pay(12), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h0C, pay(12), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h0C, pay(12), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Flush with two held entries and an incoming beat.
        step(1'b0, 1'b1, 6'h3F, pay(20), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h3F, pay(21), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h3F, pay(22), 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Interrupt while downstream is ready, then a back-to-back pair of interrupts.
        step(1'b0, 1'b1, 6'h21, pay(30), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h22, pay(31), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h23, pay(32), 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b1, 6'h24, pay(33), 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 6'h00, 96'h0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Reset with entries held; accept on the first edge after release.
        step(1'b0, 1'b1, 6'h31, pay(40), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h32, pay(41), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'h33, pay(42), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h34, pay(43), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Bubble counter saturation and hold.
        idle(66000, 1'b1);
        chk("bubble_sat0", 128'(bub_o[0]), 128'(16'hFFFF));
        chk("bubble_sat1", 128'(bub_o[1]), 128'(16'hFFFF));
        step(1'b0, 1'b0, 6'h00, 96'h0, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
